// File: rtl/io_relay_pipe_if.sv
// Handshake/bus bundle for io_relay_pipe: pin data in, launch data, enable and counters out.
interface io_relay_pipe_if #(
    parameter int CH    = 2,
    parameter int CNT_W = 8
);
    logic                  en;
    logic [1:0]            mode;
    logic                  cnt_clr;
    logic [CH-1:0]         din;
    logic [CH-1:0]         dout;
    logic                  oe;
    logic [CH*CNT_W-1:0]   toggle_cnt;

    modport master (
        output en, mode, cnt_clr, din,
        input  dout, oe, toggle_cnt
    );

    modport slave (
        input  en, mode, cnt_clr, din,
        output dout, oe, toggle_cnt
    );
endinterface

// File: rtl/io_relay_pipe.sv
// Multi-channel registered pin relay: capture register, DEPTH delay stages, mode-controlled
// launch register, priming output-enable and per-channel saturating toggle counters.
module io_relay_pipe #(
    parameter int CH          = 2,
    parameter int DEPTH       = 0,
    parameter int NEG_TRIGGER = 0,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    io_relay_pipe_if.slave bus
);
    localparam int PC_W = $clog2(DEPTH + 3);
    localparam logic [PC_W-1:0]  PC_MAX  = PC_W'(DEPTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_INV  = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_ZERO = 2'b11
    } mode_t;

    // Every register runs off the selected edge; the inversion maps onto the flop clock polarity.
    logic aclk;
    assign aclk = (NEG_TRIGGER != 0) ? ~clk : clk;

    logic [CH-1:0]    cap;
    logic [CH-1:0]    last;
    logic [CH-1:0]    dout_r;
    logic [PC_W-1:0]  pc;
    logic             oe_r;
    logic [CNT_W-1:0] cnt [CH];

    generate
        if (DEPTH == 0) begin : g_nostage
            assign last = cap;
        end else begin : g_stage
            logic [CH-1:0] stg [DEPTH];
            always_ff @(posedge aclk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
                end else if (bus.en) begin
                    stg[0] <= cap;
                    for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
                end
            end
            assign last = stg[DEPTH-1];
        end
    endgenerate

    // oe is set on the edge that pc first reaches DEPTH+2 and then sticks until reset.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            cap    <= '0;
            dout_r <= '0;
            pc     <= '0;
            oe_r   <= 1'b0;
        end else if (bus.en) begin
            cap <= bus.din;
            case (mode_t'(bus.mode))
                MODE_PASS: dout_r <= last;
                MODE_INV:  dout_r <= ~last;
                MODE_HOLD: dout_r <= dout_r;
                default:   dout_r <= '0;
            endcase
            if (pc != PC_MAX) begin
                pc <= pc + PC_W'(1);
                if (pc == PC_MAX - PC_W'(1)) oe_r <= 1'b1;
            end
        end
    end

    // Clear has priority over counting and works even while the pipeline is stalled.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) cnt[i] <= '0;
        end else if (bus.cnt_clr) begin
            for (int i = 0; i < CH; i++) cnt[i] <= '0;
        end else if (bus.en) begin
            for (int i = 0; i < CH; i++) begin
                if ((bus.din[i] != cap[i]) && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    assign bus.dout = dout_r;
    assign bus.oe   = oe_r;

    generate
        for (genvar g = 0; g < CH; g++) begin : g_cnt
            assign bus.toggle_cnt[g*CNT_W +: CNT_W] = cnt[g];
        end
    endgenerate
endmodule

// File: doc/io_relay_pipe.md
# io_relay_pipe

Multi-channel registered pin relay: captures `CH` package-pin inputs, delays them through a `DEPTH`-stage pipeline, and drives `CH` output pins from a launch register. All registers share one clock, on the edge selected by `NEG_TRIGGER`. The block sits between SB_IO input and output registers in the fuzz and test designs and generalises the single-channel, two-register pin-to-pin path. It adds:
- configurable delay and an output mode,
- an output-enable that asserts only once the pipeline is primed,
- per-channel saturating toggle counters.

## Interface
Parameters:
- `CH`, 2: channel count, ≥1.
- `DEPTH`, 0: extra delay stages between capture and launch registers, ≥0.
- `NEG_TRIGGER`, 0: 1 clocks every register on negedge `clk`, 0 on posedge.
- `CNT_W`, 8: toggle counter width per channel, ≥1.

Ports:
- `clk`, in, 1: single clock. "Active edge" below means the edge selected by `NEG_TRIGGER`.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: pipeline advance enable, sampled on the active edge.
- `mode`, in, 2: output mode.
  - 00: pass
  - 01: invert
  - 10: hold
  - 11: force 0
- `cnt_clr`, in, 1: synchronous clear of all toggle counters.
- `din`, in, `CH`: pin input data.
- `dout`, out, `CH`: launch register, drives output pins.
- `oe`, out, 1: output enable. Registered, high once the pipeline is primed.
- `toggle_cnt`, out, `CH*CNT_W`: channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Datapath per channel:
  - capture register `cap` ← `din`;
  - stages `s[0..DEPTH-1]`, where `s[0]` ← `cap` and `s[k]` ← `s[k-1]`;
  - launch register `dout` ← f(`mode`, last). "last" is `s[DEPTH-1]`, or `cap` when `DEPTH`=0.
- Launch function f:
  - pass: `dout` ← last.
  - invert: `dout` ← ~last.
  - hold: `dout` keeps its value; `cap` and the stages still shift.
  - force 0: `dout` ← 0.
- `en`=0: `cap`, all stages, `dout`, the prime counter and the toggle counters all hold. `cnt_clr` still acts.
- Prime counter `pc`:
  - width $clog2(`DEPTH`+3);
  - increments on each active edge with `en`=1 until it reaches `DEPTH`+2, then saturates;
  - `oe` is registered and set on the same edge that `pc` reaches `DEPTH`+2;
  - `oe` stays 1 until reset.
- Toggle counter per channel:
  - +1 on an active edge with `en`=1 where the new `cap` value differs from the old `cap` value;
  - saturates at 2^`CNT_W`−1 (no wrap).
- `cnt_clr`=1 on an active edge: all counters become 0. This wins over a simultaneous toggle, giving 0 rather than 1.
- `mode` changes take effect at the launch register on the next active edge. There is no glitch path and no combinational path from `din` or `mode` to any output.

## Timing
- Reset (async, immediate, independent of the clock edge): `cap`, stages, `dout`=0; `pc`=0; `oe`=0; `toggle_cnt`=0.
- Reset asserted mid-operation:
  - `oe` drops in the same instant and all data is discarded;
  - after deassertion, priming restarts from `pc`=0.
- Latency: `din` sampled at active edge E (`en`=1 throughout) appears on `dout` at edge E+`DEPTH`+1. This is `DEPTH`+2 registers in total. `DEPTH`=0 gives 2 registers, latency E+1.
- Priming:
  - the first active edge after reset with `en`=1 is edge 1;
  - `oe` rises on enabled edge `DEPTH`+2, the same edge that first-captured data lands on `dout`;
  - `en`=0 edges do not count.
- Toggle count is updated on the same edge as the `cap` change it counts, and is visible after that edge.
- `NEG_TRIGGER`=1: identical behaviour, with all timing referenced to falling edges; nothing toggles on rising edges.

## Test plan
- **Latency and priming:**
  - Stimulus: `CH`=2, `DEPTH`=3, `mode`=00, `en`=1; release reset; drive `din`=2'b01 on enabled edge 1, then 2'b10.
  - Required: `oe`=0 through edge 4 and 1 after edge 5; `dout`=01 after edge 5 and 10 after edge 6.
- **Modes:**
  - Stimulus: steady `din`=2'b10; after priming, step `mode` 01 → 10 → 11 → 00, one edge each.
  - Required: `dout` goes 01 → 01 (held) → 00 → 10, each one edge after the `mode` change.
- **Enable stall:**
  - Stimulus: deassert `en` for 4 edges mid-stream with `din` toggling.
  - Required: `dout`, `pc` and `toggle_cnt` frozen during the stall; data resumes with no loss and no duplication, shifted by exactly 4 edges.
- **Counter saturation and clear:**
  - Stimulus: `CNT_W`=3, toggle `din[0]` every edge for 10 edges, then assert `cnt_clr` together with a toggle.
  - Required: count reaches 7 and holds at 7; after the clear edge it reads 0, not 1.
- **Async reset mid-stream:**
  - Stimulus: assert `rst` between edges after priming.
  - Required: `oe`, `dout` and counters go to 0 before the next edge; after release, `oe` needs `DEPTH`+2 enabled edges again.
- **Negedge variant:**
  - Stimulus: `NEG_TRIGGER`=1, `DEPTH`=0, `CH`=1.
  - Required: `dout` updates only on falling edges; latency is one edge; `oe` rises on the second enabled falling edge.
